// File: rtl/cordic_cos_sequencer.sv
// cordic_cos_sequencer: control and datapath sequencer for an iterative CORDIC
// cosine, exposed as a multi-cycle custom instruction. The single-precision
// operand is unpacked externally (fx_float -> fx_fixed) and rotated here in
// Q2.20 using 24-bit x/y/z registers.
// Optional macro: CORDIC_COS_SAT_EN clamps the final x to [-1.0, +1.0].
module cordic_cos_sequencer #(
  parameter int ITERATIONS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic [31:0] fx_float,
  input  logic [21:0] fx_fixed,
  output logic        done,
  output logic [31:0] result,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

  localparam logic signed [23:0] K_INIT  = 24'sh09B750;
  localparam logic signed [23:0] ONE     = 24'sh100000;
  localparam logic signed [23:0] NEG_ONE = -24'sh100000;
  localparam logic [4:0]         LAST    = 5'(ITERATIONS - 1);

  state_t            state;
  logic [4:0]        i;
  logic signed [23:0] x, y, z;

  // round(atan(2^-i) * 2^20)
  function automatic logic signed [23:0] atan_rom(input logic [4:0] idx);
    case (idx)
      5'd0:    atan_rom = 24'sd823550;
      5'd1:    atan_rom = 24'sd486169;
      5'd2:    atan_rom = 24'sd256878;
      5'd3:    atan_rom = 24'sd130396;
      5'd4:    atan_rom = 24'sd65451;
      5'd5:    atan_rom = 24'sd32757;
      5'd6:    atan_rom = 24'sd16383;
      5'd7:    atan_rom = 24'sd8192;
      5'd8:    atan_rom = 24'sd4096;
      5'd9:    atan_rom = 24'sd2048;
      5'd10:   atan_rom = 24'sd1024;
      5'd11:   atan_rom = 24'sd512;
      5'd12:   atan_rom = 24'sd256;
      5'd13:   atan_rom = 24'sd128;
      5'd14:   atan_rom = 24'sd64;
      5'd15:   atan_rom = 24'sd32;
      5'd16:   atan_rom = 24'sd16;
      5'd17:   atan_rom = 24'sd8;
      5'd18:   atan_rom = 24'sd4;
      5'd19:   atan_rom = 24'sd2;
      default: atan_rom = 24'sd0;
    endcase
  endfunction

  logic               d;
  logic signed [23:0] xs, ys, at;
  logic signed [23:0] x_next, y_next, z_next;
  logic signed [23:0] x_out;

  // One micro-rotation: direction follows the sign of the residual angle.
  always_comb begin
    d      = ~z[23];
    xs     = x >>> i;
    ys     = y >>> i;
    at     = atan_rom(i);
    x_next = d ? (x - ys) : (x + ys);
    y_next = d ? (y + xs) : (y - xs);
    z_next = d ? (z - at) : (z + at);
  end

  // Final x before truncation, optionally clamped to the legal cosine range.
  always_comb begin
    x_out = x;
`ifdef CORDIC_COS_SAT_EN
    if (x > ONE)          x_out = ONE;
    else if (x < NEG_ONE) x_out = NEG_ONE;
`endif
  end

  // Control FSM with the x/y/z/i datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      i        <= '0;
      x        <= '0;
      y        <= '0;
      z        <= '0;
      fx_float <= '0;
      done     <= 1'b0;
      result   <= '0;
      busy     <= 1'b0;
    end else if (clk_en) begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          fx_float <= dataa;
          busy     <= 1'b1;
          state    <= LOAD;
        end
        LOAD: begin
          z     <= {{2{fx_fixed[21]}}, fx_fixed};
          x     <= K_INIT;
          y     <= '0;
          i     <= '0;
          state <= ITER;
        end
        ITER: begin
          x <= x_next;
          y <= y_next;
          z <= z_next;
          i <= i + 5'd1;
          if (i == LAST) state <= DONE;
        end
        DONE: begin
          result <= {{10{x_out[21]}}, x_out[21:0]};
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cordic_cos_sequencer.md
# cordic_cos_sequencer

Sequencer for the iterative CORDIC cosine datapath, presented as a Nios-II-style multi-cycle custom instruction. It latches a 32-bit IEEE-754 single operand, hands it to the external `float_to_fixed` unpacker, and loads the returned 22-bit fixed angle into its z register. It then steps the x/y/z shift-add rotation for `ITERATIONS` cycles and returns the fixed-point cosine with a one-cycle `done` pulse. It sits between the custom-instruction port and the unpacker, and owns the iteration counter, the arctangent table and the control FSM.

## Interface
- `ITERATIONS`, 16, number of CORDIC micro-rotations (legal 8..20).
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `clk_en` input 1: when low, all state and outputs hold.
- `start` input 1: request; sampled only in IDLE with `clk_en`=1.
- `dataa` input 32: IEEE-754 single angle in radians, |angle| ≤ 1.0.
- `fx_float` output 32: operand to the unpacker (registered copy of `dataa`).
- `fx_fixed` input 22: unpacker result, combinational from `fx_float`.
- `done` output 1: one-cycle completion pulse.
- `result` output 32: cosine, Q2.20 sign-extended to 32 bits.
- `busy` output 1: high in every state except IDLE.

## Operation
- Fixed format: 22-bit two's complement Q2.20, so 1.0 = 0x100000. The x, y and z registers are 24 bits wide (2 guard bits). The final x is truncated back to 22 bits.
- FSM states: IDLE, LOAD, ITER, DONE.
- IDLE → LOAD on `start`&`clk_en`. Capture `fx_float`←`dataa`.
- LOAD → ITER:
  - z←sext(`fx_fixed`).
  - x←K = 0x09B750 (0.607253·2^20).
  - y←0, i←0.
- ITER, each cycle: d = (z ≥ 0). Then:
  - x←x − (d ? y>>>i : −(y>>>i)).
  - y←y + (d ? x>>>i : −(x>>>i)).
  - z←z − (d ? atan[i] : −atan[i]).
  - i←i+1.
  - Shifts are arithmetic.
  - After i = `ITERATIONS`−1 the FSM goes to DONE.
- atan[i] = round(atan(2^−i)·2^20). atan[0] = 823550, atan[1] = 486169, atan[2] = 256878. The table is a constant ROM indexed by i.
- DONE: `result`←sext32(x[21:0]) and `done`=1 for this cycle only. Next state is IDLE.
- `start` outside IDLE is ignored; no queueing.
- `dataa` is sampled only on the IDLE→LOAD edge. Later changes have no effect on the operation in flight.
- `result` holds its last value until the next DONE.

## Timing
- Reset values: `done`=0, `busy`=0, `result`=0, `fx_float`=0, state IDLE, i=0, x=y=z=0.
- Reset mid-operation aborts to IDLE next edge. No `done` is produced and `result` is cleared to 0.
- Latency with `clk_en` held high, start sampled at edge 0:
  - LOAD at edge 1.
  - Iterations on edges 2..`ITERATIONS`+1.
  - `done`=1 in the cycle after edge `ITERATIONS`+2, which is 18 edges for the default.
- `busy` rises with the LOAD state and falls as the FSM returns to IDLE after DONE.
- `clk_en`=0 stretches latency by the number of gated cycles. A gated DONE cycle keeps `done` high until the next enabled edge.
- Back-to-back: `start` may be asserted in the first IDLE cycle after DONE. Minimum issue interval is `ITERATIONS`+3 cycles.
- Reset and `start` on the same edge: reset wins.

## Configuration
- `CORDIC_COS_SAT_EN` defined: the DONE stage clamps x to [0xF00000, 0x100000] (−1.0..+1.0) before truncation, so accumulated gain error never reports cos > 1.0.
- `CORDIC_COS_SAT_EN` undefined: raw x is truncated. cos(0) may read up to a few LSB above 0x100000.

## Test plan
- Reset, then `dataa`=0x00000000 and `start` → `done` exactly 18 cycles later, `result` within ±8 LSB of 0x00100000. With `CORDIC_COS_SAT_EN` defined, `result` ≤ 0x00100000.
- `dataa`=0x3f451eb8 (0.77) → `result` within ±16 LSB of 0x000B7C96. `dataa`=0xbd8f5c29 (−0.07) → within ±16 LSB of 0x000FF5F8.
- `dataa`=0xbf800000 (−1.0) → `result` within ±16 LSB of 0x0008A514, with the sign extension bits 31:22 equal to 0.
- `start` pulsed again at cycle 5 with a different `dataa` → ignored. A single `done` arrives at 18 cycles, carrying the first operand's result.
- `clk_en` low for 4 cycles mid-ITER → `done` arrives at 22 cycles with an unchanged result. `reset` at cycle 10 → no `done`, `result`=0, `busy`=0, and a new `start` completes normally.
